hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline control stage directly downstream of forwarding_unit.
- Consumes FW_halt and converts it, together with cache stalls and EX-stage redirects, into per-stage enable, flush and bubble controls for the 5-stage renas pipeline.
- Holds flush requests across data-cache freezes and detects stuck hazards.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 32, width of the performance counters.
- MAX_FW_HALT, 4, number of consecutive FW_halt cycles after which hz_err is set.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- FW_halt  in  1  load-use or store-data halt from forwarding_unit.
- icache_stall  in  1  instruction fetch miss.
- dcache_stall  in  1  data access not complete.
- br_flush  in  1  one-cycle redirect pulse from EX.
- trap_flush  in  1  one-cycle trap or mret redirect.
- cnt_clr  in  1  synchronous clear of the counters.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID enable.
- idex_en  out  1  ID/EX enable.
- exmem_en  out  1  EX/MEM enable.
- memwb_en  out  1  MEM/WB enable.
- ifid_flush  out  1  load bubble into IF/ID.
- idex_flush  out  1  load bubble into ID/EX.
- exmem_bubble  out  1  load bubble into EX/MEM.
- flush_active  out  1  a redirect is being applied this cycle.
- hz_err  out  1  sticky stuck-hazard flag.
- stall_cnt  out  CNT_W  count of cycles with pc_en = 0.
- flush_cnt  out  CNT_W  count of applied redirects.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State INIT.
  - All enables 0; ifid_flush, idex_flush and exmem_bubble 1.
  - pend_flush 0, halt_cnt 0, hz_err 0, both counters 0.
- States: INIT, RUN, CACHE_WAIT.
- INIT: lasts exactly one cycle after rst_n rises.
  - All flush and bubble outputs 1; pc_en 0; other enables 1.
  - Next state is always RUN.
- Outputs are combinational from state and inputs, with zero latency. Priority, highest first, when in RUN or CACHE_WAIT:
  1. dcache_stall = 1
     - All five enables 0; all flush and bubble outputs 0.
     - State becomes CACHE_WAIT.
     - If br_flush or trap_flush is 1, set pend_flush = 1.
  2. Redirect: (trap_flush or br_flush or pend_flush) and dcache_stall = 0
     - All enables 1; ifid_flush = 1, idex_flush = 1.
     - flush_active = 1; flush_cnt increments by 1.
     - pend_flush clears. State becomes RUN.
     - The redirect overrides FW_halt, because the halting instruction is squashed.
  3. FW_halt = 1
     - pc_en, ifid_en, idex_en = 0; exmem_en = 1, exmem_bubble = 1, memwb_en = 1.
     - halt_cnt increments.
  4. icache_stall = 1
     - pc_en = 0, ifid_flush = 1; other enables 1.
  5. Otherwise: all enables 1, all flush and bubble outputs 0.
     - State becomes RUN when leaving CACHE_WAIT.
- halt_cnt:
  - Clears on any cycle with FW_halt = 0 or on a redirect.
  - When halt_cnt reaches MAX_FW_HALT, hz_err is set.
  - hz_err stays set until reset.
- Counters:
  - stall_cnt counts every cycle with pc_en = 0, excluding INIT.
  - Both counters saturate at all-ones.
  - cnt_clr has priority over increment; the cycle with cnt_clr high does not count.
- Simultaneous events:
  - trap_flush and br_flush together count as one redirect (flush_cnt + 1).
  - A redirect arriving during an icache_stall is applied immediately.
  - A redirect arriving during a dcache_stall is deferred via pend_flush.
- Reset mid-operation: asynchronous return to the reset values. pend_flush is lost.

Decomposition:
- renas_package:
  - hz_state_e enum (INIT, RUN, CACHE_WAIT).
  - A pipe_ctrl_t struct bundling the enable, flush and bubble outputs.
- renas_user_parameters: CNT_W and MAX_FW_HALT defaults.
- Sub-module perf_cnt_sat (a saturating counter with clear), instantiated twice.

Test Plan:
- Reset release, idle inputs:
  - First cycle is INIT with all flush outputs 1 and pc_en 0.
  - Second cycle is RUN with all enables 1 and no flush outputs.
- FW_halt held for 1 cycle:
  - pc_en, ifid_en, idex_en = 0 and exmem_bubble = 1 for exactly that cycle.
  - stall_cnt = 1, hz_err = 0.
- dcache_stall held for 3 cycles with a br_flush pulse in its 2nd cycle:
  - All enables 0 for 3 cycles.
  - The cycle after release has ifid_flush = idex_flush = 1 and flush_cnt = 1.
- FW_halt held for 5 cycles with MAX_FW_HALT = 4: hz_err rises after the 4th cycle and stays 1 after FW_halt drops.
- br_flush and FW_halt in the same cycle: redirect wins, enables all 1, flush_cnt + 1, halt_cnt cleared.
- CNT_W = 4, hold icache_stall for 20 cycles: stall_cnt saturates at 15; pulsing cnt_clr gives 0 on the next cycle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the renas pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int CNT_W_DEF       = 32;
  localparam int MAX_FW_HALT_DEF = 4;

  typedef enum logic [1:0] {
    INIT       = 2'd0,
    RUN        = 2'd1,
    CACHE_WAIT = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_bubble;
  } pipe_ctrl_t;

  // Per-situation control patterns: {five enables, ifid_flush, idex_flush, exmem_bubble}.
  localparam pipe_ctrl_t CTRL_RESET    = 8'b00000_111;
  localparam pipe_ctrl_t CTRL_INIT     = 8'b01111_111;
  localparam pipe_ctrl_t CTRL_FREEZE   = 8'b00000_000;
  localparam pipe_ctrl_t CTRL_REDIRECT = 8'b11111_110;
  localparam pipe_ctrl_t CTRL_HALT     = 8'b00011_001;
  localparam pipe_ctrl_t CTRL_ICACHE   = 8'b01111_100;
  localparam pipe_ctrl_t CTRL_RUN      = 8'b11111_000;

endpackage

// File: rtl/perf_cnt_sat.sv
// Saturating event counter with synchronous clear taking priority over increment.
module perf_cnt_sat #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Turns forwarding halts, cache stalls and EX redirects into per-stage
// enable/flush/bubble controls, with deferred flushes and stuck-halt detection.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MAX_FW_HALT = MAX_FW_HALT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             FW_halt,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             br_flush,
  input  logic             trap_flush,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             flush_active,
  output logic             hz_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int HC_W = $clog2(MAX_FW_HALT + 1);

  hz_state_e       state, state_nxt;
  pipe_ctrl_t      ctrl;
  logic            pend_flush, pend_nxt;
  logic [HC_W-1:0] halt_cnt, halt_nxt;
  logic            stall_inc;

  // Priority decode: dcache freeze, then redirect, then FW halt, then icache miss.
  always_comb begin
    ctrl         = CTRL_RESET;
    flush_active = 1'b0;
    state_nxt    = state;
    pend_nxt     = pend_flush;
    halt_nxt     = FW_halt ? halt_cnt : '0;
    if (rst_n) begin
      case (state)
        INIT: begin
          ctrl      = CTRL_INIT;
          state_nxt = RUN;
          halt_nxt  = '0;
        end
        default: begin
          if (dcache_stall) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = CACHE_WAIT;
            if (br_flush || trap_flush) pend_nxt = 1'b1;
          end else begin
            state_nxt = RUN;
            if (br_flush || trap_flush || pend_flush) begin
              ctrl         = CTRL_REDIRECT;
              flush_active = 1'b1;
              pend_nxt     = 1'b0;
              halt_nxt     = '0;
            end else if (FW_halt) begin
              ctrl = CTRL_HALT;
              if (halt_cnt != HC_W'(MAX_FW_HALT)) halt_nxt = halt_cnt + 1'b1;
            end else if (icache_stall) begin
              ctrl = CTRL_ICACHE;
            end else begin
              ctrl = CTRL_RUN;
            end
          end
        end
      endcase
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign ifid_en      = ctrl.ifid_en;
  assign idex_en      = ctrl.idex_en;
  assign exmem_en     = ctrl.exmem_en;
  assign memwb_en     = ctrl.memwb_en;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_bubble = ctrl.exmem_bubble;

  assign stall_inc = (state != INIT) && !ctrl.pc_en;

  // hz_err latches on the same edge halt_cnt reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      pend_flush <= 1'b0;
      halt_cnt   <= '0;
      hz_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_flush <= pend_nxt;
      halt_cnt   <= halt_nxt;
      if (halt_nxt == HC_W'(MAX_FW_HALT)) hz_err <= 1'b1;
    end
  end

  perf_cnt_sat #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  perf_cnt_sat #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (flush_active),
    .cnt   (flush_cnt)
  );

endmodule
